// File: rtl/sobel_gradient_if.sv
// Pixel-stream bundle between a grayscale source and the Sobel stage, plus the gradient stream it returns.
interface sobel_gradient_if;
  logic [7:0] pixelIn;
  logic       de;
  logic       vsync;
  logic [8:0] gradientX;
  logic [8:0] gradientY;
  logic       deOut;

  modport master (
    output pixelIn, de, vsync,
    input  gradientX, gradientY, deOut
  );

  modport slave (
    input  pixelIn, de, vsync,
    output gradientX, gradientY, deOut
  );
endinterface

// File: rtl/sobel_gradient.sv
// Streaming 3x3 Sobel: two line buffers feed a 3x3 window, and the gradients are scaled by 1/4 to 9 bits.
// Fixed 3-clock latency: window load, gradient compute, output register.
module sobel_gradient #(
  parameter int unsigned IMG_WIDTH  = 1280,
  parameter int unsigned IMG_HEIGHT = 720
) (
  input logic             pclk,
  input logic             reset,
  sobel_gradient_if.slave bus
);
  localparam int unsigned ColW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RowW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [ColW-1:0] LastCol = ColW'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0] LastRow = RowW'(IMG_HEIGHT - 1);

  logic            accept;
  logic [ColW-1:0] col;
  logic [RowW-1:0] row;

  assign accept = bus.de & ~bus.vsync;

  always_ff @(posedge pclk) begin
    if (reset || bus.vsync) begin
      col <= '0;
      row <= '0;
    end else if (bus.de) begin
      if (col == LastCol) begin
        col <= '0;
        row <= (row == LastRow) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Line buffers and window are never cleared; the border flag masks stale contents.
  logic [7:0] lb0 [IMG_WIDTH];
  logic [7:0] lb1 [IMG_WIDTH];
  logic [7:0] win [3][3];
  logic [7:0] lb0Rd;
  logic [7:0] lb1Rd;

  assign lb0Rd = lb0[col];
  assign lb1Rd = lb1[col];

  always_ff @(posedge pclk) begin
    if (accept && !reset) begin
      lb1[col] <= lb0Rd;
      lb0[col] <= bus.pixelIn;
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb1Rd;
      win[1][2] <= lb0Rd;
      win[2][2] <= bus.pixelIn;
    end
  end

  logic valid1;
  logic border1;

  always_ff @(posedge pclk) begin
    if (reset) begin
      valid1  <= 1'b0;
      border1 <= 1'b0;
    end else begin
      valid1  <= accept;
      border1 <= (row < RowW'(2)) || (col < ColW'(2));
    end
  end

  function automatic logic [10:0] tap(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
  endfunction

  logic [10:0] gxDiff;
  logic [10:0] gyDiff;
  logic [3:0]  unusedFrac;

  always_comb begin
    gxDiff = tap(win[0][2], win[1][2], win[2][2]) - tap(win[0][0], win[1][0], win[2][0]);
    gyDiff = tap(win[2][0], win[2][1], win[2][2]) - tap(win[0][0], win[0][1], win[0][2]);
  end

  // Bits [10:2] of the two's-complement difference are the floored divide-by-4.
  assign unusedFrac = {gxDiff[1:0], gyDiff[1:0]};

  logic       valid2;
  logic [8:0] gx2;
  logic [8:0] gy2;
  logic       deOutQ;
  logic [8:0] gxOutQ;
  logic [8:0] gyOutQ;

  always_ff @(posedge pclk) begin
    if (reset) begin
      valid2 <= 1'b0;
      gx2    <= '0;
      gy2    <= '0;
      deOutQ <= 1'b0;
      gxOutQ <= '0;
      gyOutQ <= '0;
    end else begin
      valid2 <= valid1;
      gx2    <= (valid1 && !border1) ? gxDiff[10:2] : '0;
      gy2    <= (valid1 && !border1) ? gyDiff[10:2] : '0;
      deOutQ <= valid2;
      gxOutQ <= valid2 ? gx2 : '0;
      gyOutQ <= valid2 ? gy2 : '0;
    end
  end

  assign bus.deOut     = deOutQ;
  assign bus.gradientX = gxOutQ;
  assign bus.gradientY = gyOutQ;
endmodule

// File: tb/tb_sobel_gradient.sv
// Bench for sobel_gradient: an 8x6 and a 32x16 instance share one pixel stream; a frame-array Sobel
// model predicts every output cycle, and literal values pin the directed edge images.
module tb_sobel_gradient;
  localparam int W0 = 8;
  localparam int H0 = 6;
  localparam int W1 = 32;
  localparam int H1 = 16;

  logic       pclk  = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pix   = '0;
  logic       de    = 1'b0;
  logic       vsync = 1'b0;
  int nChecks = 0;
  int nFails  = 0;

  always #5 pclk = ~pclk;

  sobel_gradient_if busA ();
  sobel_gradient_if busB ();

  assign busA.pixelIn = pix;
  assign busA.de      = de;
  assign busA.vsync   = vsync;
  assign busB.pixelIn = pix;
  assign busB.de      = de;
  assign busB.vsync   = vsync;

  sobel_gradient #(.IMG_WIDTH(W0), .IMG_HEIGHT(H0)) dutA (
    .pclk (pclk),
    .reset(reset),
    .bus  (busA.slave)
  );

  sobel_gradient #(.IMG_WIDTH(W1), .IMG_HEIGHT(H1)) dutB (
    .pclk (pclk),
    .reset(reset),
    .bus  (busB.slave)
  );

  // Reference state: whole-frame image per instance and a 3-deep output delay line {valid, gx, gy}.
  int          wd [2] = '{W0, W1};
  int          ht [2] = '{H0, H1};
  int          col [2] = '{0, 0};
  int          row [2] = '{0, 0};
  logic [7:0]  img [2][H1][W1];
  logic [18:0] pipe [2][3] = '{default: '0};
  int          cen [3] = '{-1, -1, -1};
  logic [8:0]  gotX [H0][W0];
  logic [8:0]  gotY [H0][W0];
  bit          gotV [H0][W0];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    nChecks++;
    if (got !== want) begin
      nFails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [18:0] sobelRef(input int k, input int r, input int c);
    int q [3][3];
    int gx, gy, sx, sy;
    if (r < 2 || c < 2) return {1'b1, 18'b0};
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) q[i][j] = int'(img[k][r-2+i][c-2+j]);
    gx = (q[0][2] + 2*q[1][2] + q[2][2]) - (q[0][0] + 2*q[1][0] + q[2][0]);
    gy = (q[2][0] + 2*q[2][1] + q[2][2]) - (q[0][0] + 2*q[0][1] + q[0][2]);
    sx = gx >>> 2;
    sy = gy >>> 2;
    return {1'b1, sx[8:0], sy[8:0]};
  endfunction

  always @(posedge pclk) begin
    for (int k = 0; k < 2; k++) begin
      logic [18:0] e;
      int ce;
      e  = '0;
      ce = -1;
      if (reset) begin
        pipe[k] = '{default: '0};
        col[k]  = 0;
        row[k]  = 0;
        if (k == 0) cen = '{-1, -1, -1};
      end else begin
        if (vsync) begin
          col[k] = 0;
          row[k] = 0;
        end else if (de) begin
          img[k][row[k]][col[k]] = pix;
          e = sobelRef(k, row[k], col[k]);
          if (row[k] >= 2 && col[k] >= 2) ce = (row[k] - 1) * W0 + col[k] - 1;
          if (col[k] == wd[k] - 1) begin
            col[k] = 0;
            row[k] = (row[k] == ht[k] - 1) ? 0 : row[k] + 1;
          end else begin
            col[k]++;
          end
        end
        pipe[k][2] = pipe[k][1];
        pipe[k][1] = pipe[k][0];
        pipe[k][0] = e;
        if (k == 0) begin
          cen[2] = cen[1];
          cen[1] = cen[0];
          cen[0] = ce;
        end
      end
    end
  end

  always @(negedge pclk) begin
    check("outA{de,gx,gy}", {13'b0, busA.deOut, busA.gradientX, busA.gradientY}, {13'b0, pipe[0][2]});
    check("outB{de,gx,gy}", {13'b0, busB.deOut, busB.gradientX, busB.gradientY}, {13'b0, pipe[1][2]});
    if (busA.deOut && cen[2] >= 0) begin
      gotX[cen[2] / W0][cen[2] % W0] = busA.gradientX;
      gotY[cen[2] / W0][cen[2] % W0] = busA.gradientY;
      gotV[cen[2] / W0][cen[2] % W0] = 1'b1;
    end
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic sendPixel(input logic [7:0] p, input bit gaps);
    pix   = p;
    de    = 1'b1;
    vsync = 1'b0;
    step();
    de = 1'b0;
    if (gaps) begin
      repeat ($urandom_range(1, 3)) begin
        pix = 8'($urandom);
        step();
      end
    end
  endtask

  function automatic logic [7:0] patPix(input int kind, input int r, input int c);
    case (kind)
      0:       return (c >= 4) ? 8'd255 : 8'd0;
      1:       return (r <= 2) ? 8'd255 : 8'd0;
      2:       return 8'd100;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic sendFrame(input int kind, input int w, input int h, input bit gaps);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) sendPixel(patPix(kind, r, c), gaps);
  endtask

  task automatic frameSync(input bit withDe);
    vsync = 1'b1;
    de    = withDe;
    pix   = 8'($urandom);
    step();
    vsync = 1'b0;
    de    = 1'b0;
  endtask

  task automatic clearGot();
    for (int r = 0; r < H0; r++)
      for (int c = 0; c < W0; c++) begin
        gotX[r][c] = 9'h0AA;
        gotY[r][c] = 9'h0AA;
        gotV[r][c] = 1'b0;
      end
  endtask

  function automatic int countGot();
    int n = 0;
    for (int r = 0; r < H0; r++)
      for (int c = 0; c < W0; c++) n += int'(gotV[r][c]);
    return n;
  endfunction

  function automatic int countNonZero();
    int n = 0;
    for (int r = 0; r < H0; r++)
      for (int c = 0; c < W0; c++)
        if (gotV[r][c] && (gotX[r][c] != 9'd0 || gotY[r][c] != 9'd0)) n++;
    return n;
  endfunction

  initial begin
    step();
    step();
    check("reset_state", {13'b0, busA.deOut, busA.gradientX, busA.gradientY}, 32'd0);
    reset = 1'b0;

    // Vertical edge between cols 3 and 4
    clearGot();
    frameSync(1'b0);
    sendFrame(0, W0, H0, 1'b0);
    repeat (4) step();
    check("vedge_gx_r1c3", 32'(gotX[1][3]), 32'h0FF);
    check("vedge_gx_r4c4", 32'(gotX[4][4]), 32'h0FF);
    check("vedge_gx_r2c2", 32'(gotX[2][2]), 32'h000);
    check("vedge_gx_r2c5", 32'(gotX[2][5]), 32'h000);
    check("vedge_gy_r3c3", 32'(gotY[3][3]), 32'h000);
    check("vedge_count", 32'(countGot()), 32'd24);

    // Horizontal edge, dark below
    clearGot();
    frameSync(1'b0);
    sendFrame(1, W0, H0, 1'b0);
    repeat (4) step();
    check("hedge_gy_r2c3", 32'(gotY[2][3]), 32'h101);
    check("hedge_gy_r3c6", 32'(gotY[3][6]), 32'h101);
    check("hedge_gy_r1c3", 32'(gotY[1][3]), 32'h000);
    check("hedge_gy_r4c3", 32'(gotY[4][3]), 32'h000);
    check("hedge_gx_r2c3", 32'(gotX[2][3]), 32'h000);

    // Flat image with random de gaps
    clearGot();
    frameSync(1'b0);
    sendFrame(2, W0, H0, 1'b1);
    repeat (4) step();
    check("flat_nonzero", 32'(countNonZero()), 32'd0);
    check("flat_count", 32'(countGot()), 32'd24);

    // 1.5 frames, then vsync together with de
    frameSync(1'b0);
    sendFrame(3, W0, H0, 1'b0);
    for (int i = 0; i < 24; i++) sendPixel(8'($urandom), 1'b0);
    frameSync(1'b1);
    clearGot();
    sendFrame(3, W0, H0, 1'b0);
    repeat (4) step();
    check("vsync_count", 32'(countGot()), 32'd24);

    // Reset for one cycle at row 3, col 5
    frameSync(1'b0);
    for (int i = 0; i < 3 * W0 + 5; i++) sendPixel(8'($urandom), 1'b0);
    reset = 1'b1;
    de    = 1'b1;
    pix   = 8'($urandom);
    step();
    check("reset_drop", {31'b0, busA.deOut}, 32'd0);
    reset = 1'b0;
    de    = 1'b0;
    clearGot();
    sendFrame(3, W0, H0, 1'b0);
    repeat (4) step();
    check("reset_restart_count", 32'(countGot()), 32'd24);

    // Random 32x16 frames, second one with gaps
    frameSync(1'b0);
    sendFrame(3, W1, H1, 1'b0);
    sendFrame(3, W1, H1, 1'b1);
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/sobel_gradient.md
# sobel_gradient

Streaming 3x3 Sobel operator that converts the 8-bit grayscale pixel stream into the signed 9-bit horizontal and vertical gradients consumed by the downstream angle stage. It keeps two line buffers and a 3x3 window. Each pixel's gradients are scaled so that every value fits the angle stage's 9-bit two's-complement inputs. Output is a fixed-latency stream whose data-enable is the input data-enable delayed by 3 clocks.

## Interface
- IMG_WIDTH, 1280, active pixels per line (line-buffer depth, column wrap point)
- IMG_HEIGHT, 720, active lines per frame (row wrap point)
- pclk  input  1  pixel clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- pixelIn  input  8  unsigned grayscale pixel, valid when de=1
- de  input  1  pixel valid / data enable
- vsync  input  1  active-high frame sync; clears position counters
- gradientX  output  9  two's-complement horizontal gradient, range -255..255
- gradientY  output  9  two's-complement vertical gradient, range -255..255
- deOut  output  1  gradient valid

## Operation
- Position counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) advance only on cycles with de=1 and vsync=0. Gaps in de are allowed anywhere.
- Column wrap: a pixel at col=IMG_WIDTH-1 sets col to 0 and increments row. Row wrap: the last pixel of row IMG_HEIGHT-1 sets row to 0.
- vsync=1: col and row are set to 0, and de is ignored that cycle (no buffer write, no output). vsync has priority over a simultaneous de.
- Line buffers LB0 (previous line) and LB1 (line before that) are IMG_WIDTH x 8 and addressed by col.
  - On each accepted pixel, the buffers are read before they are written.
  - After the read, LB1[col] receives the old LB0[col], and LB0[col] receives pixelIn.
- Window: a new column {LB1[col], LB0[col], pixelIn} (top, middle, bottom) shifts in as column 2. Older data moves to columns 1 and 0. The window shifts only on accepted pixels.
- Window notation: p[r][c], where r=0 is the top row, c=0 is the oldest column, and c=2 is the newest.
- Gx = (p02 + 2p12 + p22) - (p00 + 2p10 + p20); Gy = (p20 + 2p21 + p22) - (p00 + 2p01 + p02). Both are computed at 11-bit signed width, range ±1020.
- Scaling: gradient = G >>> 2 (arithmetic shift, floor), truncated to 9 bits. This gives 1020 -> 255 (9'h0FF) and -1020 -> -255 (9'h101).
- Spatial offset: the output for accepted input (row r, col c) is the gradient centred at (r-1, c-1).
- Border rule: if r<2 or c<2 at acceptance, the window is incomplete and gradientX = gradientY = 0 for that output. deOut is still asserted.
- Centres on the last image row and the last column are never produced.
- Line-buffer contents are never cleared; the border rule masks stale data after reset or vsync.

## Timing
- Latency is exactly 3 clocks. An input accepted at rising edge N produces deOut=1 with its gradients after rising edge N+3. The pipeline split is free, provided the total is 3.
- deOut equals (de & ~vsync) delayed 3 clocks. There is one output per accepted input, with no reordering and no stalls.
- gradientX/gradientY are 0 whenever deOut=0.
- Throughput: one pixel per clock sustained, including back-to-back lines with no blanking.
- Reset values: gradientX=0, gradientY=0, deOut=0, col=0, row=0. All pipeline valid bits are cleared.
- Reset mid-frame:
  - Results in flight are dropped; deOut is 0 for the 3 cycles after reset deasserts unless new input arrives.
  - The first accepted pixel after reset is treated as row 0, col 0.
- Reset mid-line is the same case: the partial line is discarded.

## Test plan
Run with IMG_WIDTH=8 and IMG_HEIGHT=6 unless stated otherwise.
- Vertical edge: columns 0-3 = 0, columns 4-7 = 255, full frame.
  - Expect gradientX=255 at outputs centred on cols 3-4 for rows 1-4, and 0 elsewhere.
  - Expect gradientY=0 everywhere.
- Horizontal edge, dark below: rows 0-2 = 255, rows 3-5 = 0.
  - Expect gradientY=-255 (9'h101) at centres on rows 2-3, and gradientX=0.
- Border/latency: flat image of 100.
  - Every output is 0.
  - deOut is exactly the input de delayed 3 cycles, including on a de pattern with random 1-3 cycle gaps.
- Wrap and vsync: stream 1.5 frames, assert vsync mid-frame together with de=1.
  - The pixel in that cycle produces no deOut.
  - The next pixel is treated as row 0, col 0, so the first 2 rows of output are zero.
  - Later gradients match a software Sobel on the new frame.
- Reset mid-line: assert reset for 1 cycle at row 3, col 5.
  - deOut drops to 0 within 1 cycle and no stale outputs appear.
  - The following pixels restart at row 0, col 0 with zeroed borders.
- Random image: 32x16 random pixels compared against a reference model (Sobel, >>>2, border and offset rules), checking all outputs bit-exact.
